cache_axi_rd_arbiter: RTL

//  Shares one AXI4 read channel (address + data) between the icache and dcache miss FSMs.

---
 rtl/cache_axi_rd_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/cache_axi_rd_arbiter.sv
// cache_axi_rd_arbiter: round-robin share of one AXI4 read channel between icache and dcache
module cache_axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_arvalid,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic [LEN_W-1:0]  i_arlen,
    output logic              i_arready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rlast,
    input  logic              i_rready,
    input  logic              d_arvalid,
    input  logic [ADDR_W-1:0] d_araddr,
    input  logic [LEN_W-1:0]  d_arlen,
    output logic              d_arready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rlast,
    input  logic              d_rready,
    output logic              m_arvalid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [LEN_W-1:0]  m_arlen,
    output logic              m_arid,
    input  logic              m_arready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rlast,
    output logic              m_rready,
    output logic              proto_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_nxt;
    logic last_grant;
    logic [LEN_W:0] beat_cnt;
    logic in_data, beat, bad_beat, to_i, to_d;
    always_comb begin
        d_arready = (state == IDLE) & d_arvalid & (~i_arvalid | ~last_grant);
        i_arready = (state == IDLE) & i_arvalid & ~d_arready;
        in_data   = state == DATA;
        to_i      = in_data & ~m_arid;
        to_d      = in_data & m_arid;
        m_rready  = to_d ? d_rready : to_i & i_rready;
        i_rvalid  = to_i & m_rvalid;
        i_rlast   = to_i & m_rlast;
        i_rdata   = to_i ? m_rdata : '0;
        d_rvalid  = to_d & m_rvalid;
        d_rlast   = to_d & m_rlast;
        d_rdata   = to_d ? m_rdata : '0;
        beat      = m_rvalid & m_rready;
        // rlast must coincide exactly with the beat numbered arlen
        bad_beat  = beat & (m_rlast != (beat_cnt == {1'b0, m_arlen}));
        state_nxt = state == IDLE ? ((i_arready | d_arready) ? ADDR : IDLE) :
                    state == ADDR ? (m_arready ? DATA : ADDR) :
                    ((beat & m_rlast) ? IDLE : DATA);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_arvalid  <= 1'b0;
            m_araddr   <= '0;
            m_arlen    <= '0;
            m_arid     <= 1'b0;
            last_grant <= 1'b0;
            beat_cnt   <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (i_arready | d_arready) begin
                m_arvalid  <= 1'b1;
                m_araddr   <= d_arready ? d_araddr : i_araddr;
                m_arlen    <= d_arready ? d_arlen : i_arlen;
                m_arid     <= d_arready;
                last_grant <= d_arready;
                beat_cnt   <= '0;
            end else if (state == ADDR && m_arready) begin
                m_arvalid <= 1'b0;
            end
            if (beat) beat_cnt <= beat_cnt + 1'b1;
            if (bad_beat) proto_err <= 1'b1;
        end
    end
endmodule
